// File: rtl/icache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_unit
// Purpose  : Instruction-cache line refill engine. It fetches one line as
//            LINE_WORDS single-word reads on a req/gnt/rvalid bus and returns
//            it with a one-cycle line_ready pulse. It can be aborted on a
//            pipeline flush.
// Options  : ICACHE_REFILL_CWF_EN enables critical-word-first beat ordering.
// Revision : 1.0 - initial release
// ============================================================================
module icache_refill_unit #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic                         abort,
    output logic                         line_ready,
    output logic [DATA_W*LINE_WORDS-1:0] line_data,
    output logic                         busy,
    output logic                         rd_req,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_gnt,
    input  logic                         rd_rvalid,
    input  logic [DATA_W-1:0]            rd_rdata
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              base_q, base_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IDX_W-1:0]               cnt_q, cnt_d;
    logic [DATA_W*LINE_WORDS-1:0]   line_q, line_d;
    logic [IDX_W-1:0]               start_idx;
    logic                           unused_addr_bits;

`ifdef ICACHE_REFILL_CWF_EN
    assign start_idx = req_addr[OFF_W-1:2];
`else
    assign start_idx = '0;
`endif
    // Offset bits only select the start word (if at all); the line base ignores them.
    assign unused_addr_bits = ^req_addr[OFF_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        rd_req     = 1'b0;
        rd_addr    = '0;
        line_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !abort) begin
                    base_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    idx_d   = start_idx;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                rd_req  = 1'b1;
                rd_addr = base_q | (ADDR_W'(idx_q) << 2);
                if (rd_gnt) begin
                    // A granted read must still have its data consumed.
                    state_d = abort ? DRAIN : DATA;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (rd_rvalid) begin
                    if (abort) begin
                        state_d = IDLE;
                    end else begin
                        for (int k = 0; k < LINE_WORDS; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                line_d[k*DATA_W +: DATA_W] = rd_rdata;
                            end
                        end
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = (cnt_q == LAST_BEAT) ? DONE : ADDR;
                    end
                end else if (abort) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                line_ready = !abort;
                state_d    = IDLE;
            end
            DRAIN: begin
                if (rd_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign line_data = line_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_refill_unit
// Purpose  : Self-checking bench for icache_refill_unit with a delayed-response
//            bus model and a line/latency reference built from the refill rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_refill_unit;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         abort;
    logic         line_ready;
    logic [127:0] line_data;
    logic         busy;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_gnt;
    logic         rd_rvalid;
    logic [31:0]  rd_rdata;

    int errors;
    int checks;

    // Bus model controls and observations
    int          gnt_dly;
    int          rv_dly;
    bit          rand_mode;
    logic [31:0] salt;
    int          wait_sum;
    bit          addr_unstable;
    logic [31:0] addr_log[$];
    int          lr_count;

    // Bus model state
    int          gcnt, gd, rw;
    bit          waiting, pend;
    logic [31:0] paddr, first_addr;

    icache_refill_unit #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .abort      (abort),
        .line_ready (line_ready),
        .line_data  (line_data),
        .busy       (busy),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_rvalid  (rd_rvalid),
        .rd_rdata   (rd_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (salt == 32'd0) return 32'hA0 + {30'd0, a[3:2]};
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Memory-side responder: grant after gd waits, data after rw waits.
    initial begin
        rd_gnt = 1'b0; rd_rvalid = 1'b0; rd_rdata = '0;
        waiting = 1'b0; pend = 1'b0; gcnt = 0; gd = 0; rw = 0;
        forever begin
            @(negedge clk);
            rd_gnt = 1'b0; rd_rvalid = 1'b0; rd_rdata = '0;
            if (rst) begin
                waiting = 1'b0; pend = 1'b0;
            end else if (pend) begin
                if (rw == 0) begin
                    rd_rvalid = 1'b1;
                    rd_rdata  = mem_word(paddr);
                    pend      = 1'b0;
                end else begin
                    rw--;
                end
            end else if (rd_req) begin
                if (!waiting) begin
                    waiting    = 1'b1;
                    gcnt       = 0;
                    first_addr = rd_addr;
                    gd         = rand_mode ? int'($urandom_range(0, 3)) : gnt_dly;
                end else if (rd_addr !== first_addr) begin
                    addr_unstable = 1'b1;
                end
                if (gcnt == gd) begin
                    rd_gnt  = 1'b1;
                    waiting = 1'b0;
                    addr_log.push_back(rd_addr);
                    pend    = 1'b1;
                    paddr   = rd_addr;
                    rw      = rand_mode ? int'($urandom_range(0, 3)) : rv_dly;
                    wait_sum += gd + rw;
                end else begin
                    gcnt++;
                end
            end else begin
                waiting = 1'b0;
            end
        end
    end

    initial begin
        lr_count = 0;
        forever begin
            @(negedge clk);
            if (line_ready) lr_count++;
        end
    end

    // One complete refill checked against the line, order and latency rules.
    task automatic run_fill(input logic [31:0] a);
        logic [127:0] exp_line;
        logic [31:0]  base, exp_a;
        int           start, cyc, lr0;
        bit           got;
        base = a & ~32'hF;
`ifdef ICACHE_REFILL_CWF_EN
        start = int'(a[3:2]);
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = mem_word(base + 32'(4*k));
        addr_log.delete();
        wait_sum = 0;
        addr_unstable = 1'b0;
        lr0 = lr_count;
        @(negedge clk);
        req_addr  = a;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy a=%h got=%b want=1", a, busy); end
        got = 1'b0;
        while (!got && cyc < 400) begin
            if (line_ready === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        checks++;
        if (!got || cyc != 9 + wait_sum) begin
            errors++; $display("FAIL fill_latency a=%h got=%0d want=%0d", a, cyc, 9 + wait_sum);
        end
        checks++;
        if (line_data !== exp_line) begin
            errors++; $display("FAIL fill_line a=%h got=%h want=%h", a, line_data, exp_line);
        end
        checks++;
        if (addr_log.size() != 4) begin
            errors++; $display("FAIL fill_beats a=%h got=%0d want=4", a, addr_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_a = base + 32'(4*((start + k) % 4));
                checks++;
                if (addr_log[k] !== exp_a) begin
                    errors++; $display("FAIL fill_addr[%0d] got=%h want=%h", k, addr_log[k], exp_a);
                end
            end
        end
        checks++;
        if (addr_unstable) begin errors++; $display("FAIL rd_addr_stable got=changed want=held"); end
        @(posedge clk); #1;
        checks++;
        if (line_ready !== 1'b0 || busy !== 1'b0 || line_data !== exp_line) begin
            errors++;
            $display("FAIL fill_after got=lr%b busy%b want=lr0 busy0 line held", line_ready, busy);
        end
        checks++;
        if (lr_count - lr0 != 1) begin
            errors++; $display("FAIL fill_pulses got=%0d want=1", lr_count - lr0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0 || line_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got=busy%b req%b lr%b want=000", busy, rd_req, line_ready);
        end
        checks++;
        if (rd_addr !== 32'd0 || line_data !== 128'd0) begin
            errors++; $display("FAIL reset_data got=%h/%h want=0", rd_addr, line_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        salt = 32'd0; rand_mode = 1'b0; gnt_dly = 0; rv_dly = 0;
        run_fill(32'h1C00_0024);
    endtask

    task automatic test_wait_states();
        salt = 32'd0; rand_mode = 1'b0; gnt_dly = 2; rv_dly = 3;
        run_fill(32'h1C00_0024);
    endtask

    task automatic test_abort_addr();
        int lr0;
        salt = 32'd0; rand_mode = 1'b0; gnt_dly = 10; rv_dly = 0;
        addr_log.delete();
        lr0 = lr_count;
        @(negedge clk);
        req_addr = 32'h1C00_0040; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0) begin
            errors++; $display("FAIL abort_addr_idle got=busy%b req%b want=00", busy, rd_req);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (addr_log.size() != 0 || lr_count != lr0 || rd_req !== 1'b0) begin
            errors++; $display("FAIL abort_addr_quiet got=%0d grants %0d ready want=0 0", addr_log.size(), lr_count - lr0);
        end
        gnt_dly = 0;
        run_fill(32'h2000_0000);
    endtask

    task automatic test_abort_data();
        int lr0, n;
        bit req_seen;
        salt = 32'h5A5A_1234; rand_mode = 1'b0; gnt_dly = 0; rv_dly = 4;
        addr_log.delete();
        lr0 = lr_count;
        @(negedge clk);
        req_addr = 32'h3000_0010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (addr_log.size() < 2 && n < 200) begin @(negedge clk); #1; n++; end
        @(negedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || rd_req !== 1'b0) begin
            errors++; $display("FAIL abort_data_drain got=busy%b req%b want=10", busy, rd_req);
        end
        n = 0;
        while (busy === 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_data_idle got=busy%b want=0", busy); end
        req_seen = 1'b0;
        repeat (6) begin @(negedge clk); if (rd_req) req_seen = 1'b1; end
        checks++;
        if (req_seen || addr_log.size() != 2 || lr_count != lr0) begin
            errors++; $display("FAIL abort_data_quiet got=req%b grants%0d ready%0d want=0 2 0", req_seen, addr_log.size(), lr_count - lr0);
        end
    endtask

    task automatic test_async_reset();
        int n;
        salt = 32'h0BAD_F00D; rand_mode = 1'b0; gnt_dly = 0; rv_dly = 5;
        addr_log.delete();
        @(negedge clk);
        req_addr = 32'h4000_0034; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (addr_log.size() < 1 && n < 200) begin @(negedge clk); #1; n++; end
        @(negedge clk); #2;
        checks++;
        if (busy !== 1'b1 || line_data === 128'd0) begin
            errors++; $display("FAIL async_pre got=busy%b line=%h want=busy1 line!=0", busy, line_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rd_req !== 1'b0 || line_ready !== 1'b0 || rd_addr !== 32'd0 || line_data !== 128'd0) begin
            errors++; $display("FAIL async_reset got=busy%b req%b line=%h want=all zero", busy, rd_req, line_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rv_dly = 0;
        run_fill(32'h4000_0034);
    endtask

    task automatic test_cwf();
        salt = 32'd0; rand_mode = 1'b0; gnt_dly = 0; rv_dly = 0;
        run_fill(32'h1C00_0028);
    endtask

    task automatic test_back_to_back();
        salt = $urandom() | 32'd1;
        rand_mode = 1'b1;
        for (int i = 0; i < 15; i++) run_fill($urandom());
        rand_mode = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; abort = 1'b0;
        gnt_dly = 0; rv_dly = 0; rand_mode = 1'b0; salt = '0;
        wait_sum = 0; addr_unstable = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_abort_addr();
        test_abort_data();
        test_async_reset();
        test_cwf();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
